ad9361_ensm_ctrl: RTL and testbench

- Sequences the AD9361 ENSM control pins (enable, txnrx) for the LVDS interface from two direction requests, RX and TX.
- Enforces txnrx setup time, minimum on-time and off-guard time between state changes.
- Supports level mode and pulse mode.
- Sits between the TDD/software request logic and the axi_ad9361 enable/txnrx outputs.

---
 rtl/ad9361_ensm_ctrl.sv | 144 ++++++++++++++
 tb/tb_ad9361_ensm_ctrl.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/ad9361_ensm_ctrl.sv
// AD9361 ENSM pin sequencer: arbitrates RX/TX level requests into enable/txnrx
// with txnrx setup, minimum on-time and off-guard, in level or pulse mode.
module ad9361_ensm_ctrl #(
  parameter bit TX_PRIORITY   = 1'b1,
  parameter int SETUP_CYCLES  = 4,
  parameter int MIN_ON_CYCLES = 16,
  parameter int GUARD_CYCLES  = 8,
  parameter int PULSE_WIDTH   = 2,
  parameter int CNT_WIDTH     = 16
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       rx_req,
  input  logic       tx_req,
  input  logic       pulse_mode,
  output logic       enable,
  output logic       txnrx,
  output logic       rx_active,
  output logic       tx_active,
  output logic       busy,
  output logic [1:0] state
);

  typedef enum logic [1:0] {
    ST_ALERT = 2'd0,
    ST_SETUP = 2'd1,
    ST_ON    = 2'd2,
    ST_GUARD = 2'd3
  } state_t;

  localparam int SU_E  = (SETUP_CYCLES  < 1) ? 1 : SETUP_CYCLES;
  localparam int MIN_E = (MIN_ON_CYCLES < 1) ? 1 : MIN_ON_CYCLES;
  localparam int GD_E  = (GUARD_CYCLES  < 1) ? 1 : GUARD_CYCLES;
  localparam int PW_E  = (PULSE_WIDTH   < 1) ? 1 : PULSE_WIDTH;
  // In pulse mode ON and GUARD last at least one full pulse so pulses never merge.
  localparam int ON_P  = (MIN_E > PW_E) ? MIN_E : PW_E;
  localparam int GD_P  = (GD_E  > PW_E) ? GD_E  : PW_E;

  localparam logic [CNT_WIDTH-1:0] SU_LAST   = CNT_WIDTH'(SU_E - 1);
  localparam logic [CNT_WIDTH-1:0] ON_LAST_L = CNT_WIDTH'(MIN_E - 1);
  localparam logic [CNT_WIDTH-1:0] ON_LAST_P = CNT_WIDTH'(ON_P - 1);
  localparam logic [CNT_WIDTH-1:0] GD_LAST_L = CNT_WIDTH'(GD_E - 1);
  localparam logic [CNT_WIDTH-1:0] GD_LAST_P = CNT_WIDTH'(GD_P - 1);
  localparam logic [CNT_WIDTH-1:0] PW_C      = CNT_WIDTH'(PW_E);

  state_t               r_state;
  logic [CNT_WIDTH-1:0] r_cnt;
  logic                 r_txnrx, r_mode, r_enable, r_rx_act, r_tx_act, r_busy;

  state_t               w_nxt_state;
  logic [CNT_WIDTH-1:0] w_nxt_cnt, w_cnt_inc;
  logic                 w_nxt_txnrx, w_nxt_mode, w_nxt_enable;
  logic                 w_nxt_rx_act, w_nxt_tx_act, w_nxt_busy;
  logic                 w_grant_dir, w_dir_req;

  assign w_cnt_inc   = (&r_cnt) ? r_cnt : r_cnt + 1'b1;
  assign w_grant_dir = (rx_req && tx_req) ? TX_PRIORITY : tx_req;
  assign w_dir_req   = r_txnrx ? tx_req : rx_req;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state  <= ST_ALERT;
      r_cnt    <= '0;
      r_txnrx  <= 1'b0;
      r_mode   <= 1'b0;
      r_enable <= 1'b0;
      r_rx_act <= 1'b0;
      r_tx_act <= 1'b0;
      r_busy   <= 1'b0;
    end else begin
      r_state  <= w_nxt_state;
      r_cnt    <= w_nxt_cnt;
      r_txnrx  <= w_nxt_txnrx;
      r_mode   <= w_nxt_mode;
      r_enable <= w_nxt_enable;
      r_rx_act <= w_nxt_rx_act;
      r_tx_act <= w_nxt_tx_act;
      r_busy   <= w_nxt_busy;
    end
  end

  always_comb begin
    w_nxt_state = r_state;
    w_nxt_cnt   = w_cnt_inc;
    w_nxt_txnrx = r_txnrx;
    w_nxt_mode  = r_mode;
    case (r_state)
      ST_ALERT: begin
        w_nxt_cnt = '0;
        if (rx_req || tx_req) begin
          w_nxt_state = ST_SETUP;
          w_nxt_txnrx = w_grant_dir;
          w_nxt_mode  = pulse_mode;
        end
      end
      ST_SETUP: begin
        // A dropped request aborts before enable is ever touched.
        if (!w_dir_req) begin
          w_nxt_state = ST_ALERT;
          w_nxt_cnt   = '0;
        end else if (r_cnt >= SU_LAST) begin
          w_nxt_state = ST_ON;
          w_nxt_cnt   = '0;
        end
      end
      ST_ON: begin
        if (!w_dir_req && (r_cnt >= (r_mode ? ON_LAST_P : ON_LAST_L))) begin
          w_nxt_state = ST_GUARD;
          w_nxt_cnt   = '0;
        end
      end
      ST_GUARD: begin
        if (r_cnt >= (r_mode ? GD_LAST_P : GD_LAST_L)) begin
          w_nxt_state = ST_ALERT;
          w_nxt_cnt   = '0;
        end
      end
      default: begin
        w_nxt_state = ST_ALERT;
        w_nxt_cnt   = '0;
      end
    endcase
  end

  // Outputs are decoded from the next state so they register on the same edge.
  always_comb begin
    w_nxt_enable = 1'b0;
    if (w_nxt_state == ST_ON)
      w_nxt_enable = !w_nxt_mode || (w_nxt_cnt < PW_C);
    else if (w_nxt_state == ST_GUARD)
      w_nxt_enable = w_nxt_mode && (w_nxt_cnt < PW_C);
    w_nxt_rx_act = (w_nxt_state == ST_ON) && !w_nxt_txnrx;
    w_nxt_tx_act = (w_nxt_state == ST_ON) &&  w_nxt_txnrx;
    w_nxt_busy   = (w_nxt_state != ST_ALERT);
  end

  assign enable    = r_enable;
  assign txnrx     = r_txnrx;
  assign rx_active = r_rx_act;
  assign tx_active = r_tx_act;
  assign busy      = r_busy;
  assign state     = r_state;

endmodule

// File: tb/tb_ad9361_ensm_ctrl.sv
// Bench for ad9361_ensm_ctrl: each request episode is predicted from a timeline
// formula (grant, ON entry, exit, guard end) and checked every cycle.
module tb_ad9361_ensm_ctrl;

  localparam int SU    = 4;
  localparam int MINON = 16;
  localparam int GDC   = 8;
  localparam int PW    = 2;

  logic       clk = 1'b0;
  logic       resetn;
  logic       rx_req, tx_req, pulse_mode;
  logic       enable, txnrx, rx_active, tx_active, busy;
  logic [1:0] state;
  logic       enable2, txnrx2, rx_active2, tx_active2, busy2;
  logic [1:0] state2;

  int  n_tests = 0;
  int  n_fail  = 0;
  bit  exp_txnrx = 1'b0;

  ad9361_ensm_ctrl #(.TX_PRIORITY(1'b1)) u_dut (
    .clk(clk), .resetn(resetn), .rx_req(rx_req), .tx_req(tx_req),
    .pulse_mode(pulse_mode), .enable(enable), .txnrx(txnrx),
    .rx_active(rx_active), .tx_active(tx_active), .busy(busy), .state(state));

  ad9361_ensm_ctrl #(.TX_PRIORITY(1'b0)) u_dut_rxp (
    .clk(clk), .resetn(resetn), .rx_req(rx_req), .tx_req(tx_req),
    .pulse_mode(pulse_mode), .enable(enable2), .txnrx(txnrx2),
    .rx_active(rx_active2), .tx_active(tx_active2), .busy(busy2), .state(state2));

  always #5 clk = ~clk;

  // Expected {state, enable, txnrx, rx_active, tx_active, busy} in cycle c of an
  // episode whose request was high during cycles 0..l-1 (cycle c = after edge c).
  function automatic logic [6:0] ep_exp(input int c, input bit dir, input int l,
                                        input bit pm, input bit prev);
    int e, onl, gd, x;
    logic [1:0] st;
    logic en, act;
    e   = SU + 1;
    onl = pm ? ((MINON > PW) ? MINON : PW) : MINON;
    gd  = pm ? ((GDC > PW) ? GDC : PW) : GDC;
    x   = (l > e + onl - 1) ? l : e + onl - 1;
    st = 2'd0; en = 1'b0; act = 1'b0;
    if (c == 0) return {2'd0, 1'b0, prev, 3'b000};
    if (l <= SU) st = (c <= l) ? 2'd1 : 2'd0;
    else if (c < e) st = 2'd1;
    else if (c <= x) begin
      st = 2'd2; act = 1'b1; en = pm ? (c < e + PW) : 1'b1;
    end else if (c <= x + gd) begin
      st = 2'd3; en = pm && (c <= x + PW);
    end
    return {st, en, dir, act && !dir, act && dir, st != 2'd0};
  endfunction

  function automatic int ep_end(input int l, input bit pm);
    int onl, gd, x;
    onl = pm ? ((MINON > PW) ? MINON : PW) : MINON;
    gd  = pm ? ((GDC > PW) ? GDC : PW) : GDC;
    x   = (l > SU + onl) ? l : SU + onl;
    return (l <= SU) ? l + 1 : x + gd + 1;
  endfunction

  // Entered and left just after a negedge with the DUT idle in ALERT.
  task automatic run_ep(input bit rxq, input bit txq, input int l_rx, input int l_tx,
                        input bit pm, input bit chk2, input string tag);
    bit dir1, dir2, ep2;
    int l1, l_oth, a1, l2, total;
    logic [6:0] exp_v, got_v;
    dir1  = (rxq && txq) ? 1'b1 : txq;
    l1    = dir1 ? l_tx : l_rx;
    l_oth = (rxq && txq) ? (dir1 ? l_rx : l_tx) : 0;
    a1    = ep_end(l1, pm);
    ep2   = l_oth > a1;
    dir2  = !dir1;
    l2    = l_oth - a1;
    total = a1 + (ep2 ? ep_end(l2, pm) : 0) + 2;
    for (int c = 0; c < total; c++) begin
      rx_req     = rxq && (c < l_rx);
      tx_req     = txq && (c < l_tx);
      pulse_mode = (c == 0 || c == a1) ? pm : 1'($urandom);
      if (ep2 && c >= a1) exp_v = ep_exp(c - a1, dir2, l2, pm, dir1);
      else                exp_v = ep_exp(c, dir1, l1, pm, exp_txnrx);
      got_v = {state, enable, txnrx, rx_active, tx_active, busy};
      n_tests++;
      assert (got_v === exp_v) else begin
        n_fail++;
        $error("FAIL %s cycle %0d: got st/en/tx/rxa/txa/busy=%b want %b", tag, c, got_v, exp_v);
      end
      if (chk2 && c == 1) begin
        n_tests++;
        assert (txnrx2 === 1'b0) else begin
          n_fail++;
          $error("FAIL %s rx-priority grant: got txnrx=%b want 0", tag, txnrx2);
        end
      end
      @(posedge clk);
      @(negedge clk);
    end
    exp_txnrx = ep2 ? dir2 : dir1;
  endtask

  initial begin
    logic [6:0] exp_v;
    resetn = 1'b0; rx_req = 1'b0; tx_req = 1'b0; pulse_mode = 1'b0;
    repeat (2) @(negedge clk);
    n_tests++;
    assert ({state, enable, txnrx, rx_active, tx_active, busy,
             state2, enable2, txnrx2, rx_active2, tx_active2, busy2} === 14'd0) else begin
      n_fail++;
      $error("FAIL reset: got %b/%b want all zero",
             {state, enable, txnrx, rx_active, tx_active, busy},
             {state2, enable2, txnrx2, rx_active2, tx_active2, busy2});
    end
    resetn = 1'b1;
    @(negedge clk);

    // Simultaneous rise: TX wins here, RX on the other instance; held RX turns around.
    run_ep(1'b1, 1'b1, 60, 20, 1'b0, 1'b1, "turnaround");
    run_ep(1'b0, 1'b1, 0, 40, 1'b0, 1'b0, "level_tx40");
    run_ep(1'b0, 1'b1, 0, 7,  1'b0, 1'b0, "level_short");
    run_ep(1'b0, 1'b1, 0, 2,  1'b0, 1'b0, "abort_l2");
    run_ep(1'b1, 1'b0, 4, 0,  1'b0, 1'b0, "abort_l4");
    run_ep(1'b1, 1'b0, 5, 0,  1'b0, 1'b0, "setup_edge");
    run_ep(1'b0, 1'b1, 0, 7,  1'b1, 1'b0, "pulse_tx");
    run_ep(1'b1, 1'b0, 30, 0, 1'b1, 1'b0, "pulse_rx_long");

    // Reset in mid-ON with the request still held.
    tx_req = 1'b1; rx_req = 1'b0; pulse_mode = 1'b0;
    repeat (9) begin @(posedge clk); @(negedge clk); end
    exp_v = ep_exp(9, 1'b1, 100, 1'b0, exp_txnrx);
    n_tests++;
    assert ({state, enable, txnrx, rx_active, tx_active, busy} === exp_v) else begin
      n_fail++;
      $error("FAIL pre_reset_on: got %b want %b",
             {state, enable, txnrx, rx_active, tx_active, busy}, exp_v);
    end
    resetn = 1'b0;
    #1;
    n_tests++;
    assert ({state, enable, txnrx, rx_active, tx_active, busy} === 7'd0) else begin
      n_fail++;
      $error("FAIL async_reset: got %b want 0000000",
             {state, enable, txnrx, rx_active, tx_active, busy});
    end
    @(negedge clk);
    resetn = 1'b1;
    exp_txnrx = 1'b0;
    run_ep(1'b0, 1'b1, 0, 25, 1'b0, 1'b0, "post_reset");

    for (int i = 0; i < 12; i++) begin
      int pat;
      pat = int'($urandom_range(1, 3));
      run_ep(pat[0], pat[1], int'($urandom_range(1, 45)), int'($urandom_range(1, 45)),
             1'($urandom), 1'b0, "random");
      repeat (int'($urandom_range(0, 3))) begin
        rx_req = 1'b0; tx_req = 1'b0;
        @(posedge clk); @(negedge clk);
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
